// File: rtl/alu_config_sequencer.sv
// Reprograms one building block's firmware tables from a host-filled byte FIFO (optional CFG_CHECKSUM_EN).
// Latency: start at t -> tracing low at t+1, bytes t+DRAIN_CYCLES+1.., done one cycle after the last byte.
// Backpressure: cfg_wr_ready drops while the FIFO is full; the config stream itself never stalls.
module alu_config_sequencer #(
  parameter int          MAX_CHAINS      = 4,
  parameter int          CFG_FIELDS      = 5,
  parameter int          BYTES_PER_BLOCK = MAX_CHAINS * CFG_FIELDS,
  parameter int          FIFO_DEPTH      = 32,
  parameter int          DRAIN_CYCLES    = 4,
  parameter logic [7:0]  IDLE_CONFIG_ID  = 8'hFF
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              tracing_req,
  input  logic                              cfg_wr_valid,
  input  logic [7:0]                        cfg_wr_data,
  output logic                              cfg_wr_ready,
  input  logic                              start,
  input  logic [7:0]                        block_id,
  output logic                              tracing,
  output logic [7:0]                        configId,
  output logic [7:0]                        configData,
  output logic                              busy,
  output logic                              done,
  output logic                              error,
`ifdef CFG_CHECKSUM_EN
  output logic [7:0]                        cfg_checksum,
`endif
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int SW = $clog2(BYTES_PER_BLOCK + DRAIN_CYCLES + 1);

  localparam logic [CW-1:0] LP_FULL       = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] LP_BPB_CNT    = CW'(BYTES_PER_BLOCK);
  localparam logic [PW-1:0] LP_PTR_LAST   = PW'(FIFO_DEPTH - 1);
  localparam logic [SW-1:0] LP_DRAIN_LAST = SW'(DRAIN_CYCLES - 1);
  localparam logic [SW-1:0] LP_LOAD_LAST  = SW'(BYTES_PER_BLOCK - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic [1:0]    r_state;
  logic [SW-1:0] r_cnt;
  logic [7:0]    r_block_id;
  logic          r_tracing;
  logic [7:0]    r_config_id;
  logic [7:0]    r_config_data;
  logic          r_busy;
  logic          r_done;
  logic          r_error;

  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_drain_last;
  logic          w_load_last;
  logic          w_start_ok;
  logic [7:0]    w_head;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == LP_PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  assign w_full       = (r_count == LP_FULL);
  assign w_push       = cfg_wr_valid & ~w_full;
  assign w_drain_last = (r_state == ST_DRAIN) && (r_cnt == LP_DRAIN_LAST);
  assign w_load_last  = (r_state == ST_LOAD) && (r_cnt == LP_LOAD_LAST);
  // The first byte is popped on the edge that enters LOAD so it is on the bus in the first LOAD cycle.
  assign w_pop        = w_drain_last | ((r_state == ST_LOAD) & ~w_load_last);
  assign w_head       = r_mem[r_rd_ptr];
  assign w_start_ok   = (r_count >= LP_BPB_CNT) && (block_id != IDLE_CONFIG_ID);

  assign cfg_wr_ready = ~w_full;
  assign fifo_count   = r_count;
  assign tracing      = r_tracing;
  assign configId     = r_config_id;
  assign configData   = r_config_data;
  assign busy         = r_busy;
  assign done         = r_done;
  assign error        = r_error;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= cfg_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ptr_next(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_next(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_block_id    <= IDLE_CONFIG_ID;
      r_tracing     <= 1'b0;
      r_config_id   <= IDLE_CONFIG_ID;
      r_config_data <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_tracing   <= tracing_req;
          r_config_id <= IDLE_CONFIG_ID;
          r_cnt       <= '0;
          if (start) begin
            if (w_start_ok) begin
              r_block_id <= block_id;
              r_state    <= ST_DRAIN;
              r_tracing  <= 1'b0;
              r_busy     <= 1'b1;
            end else begin
              r_error <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (w_drain_last) begin
            r_state       <= ST_LOAD;
            r_cnt         <= '0;
            r_config_id   <= r_block_id;
            r_config_data <= w_head;
          end else begin
            r_cnt <= r_cnt + SW'(1);
          end
        end
        ST_LOAD: begin
          if (w_load_last) begin
            // Idle id for one cycle resynchronises the target's byte counter.
            r_state       <= ST_GAP;
            r_cnt         <= '0;
            r_config_id   <= IDLE_CONFIG_ID;
            r_config_data <= '0;
            r_done        <= 1'b1;
          end else begin
            r_cnt         <= r_cnt + SW'(1);
            r_config_data <= w_head;
          end
        end
        ST_GAP: begin
          r_state   <= ST_IDLE;
          r_busy    <= 1'b0;
          r_tracing <= tracing_req;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef CFG_CHECKSUM_EN
  logic [7:0] r_csum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_csum <= '0;
    end else if (w_drain_last) begin
      r_csum <= w_head;
    end else if (w_pop) begin
      r_csum <= r_csum + w_head;
    end
  end

  assign cfg_checksum = r_csum;
`endif

endmodule

// File: tb/tb_alu_config_sequencer.sv
// Directed bench for alu_config_sequencer with a byte scoreboard tracking FIFO contents.
module tb_alu_config_sequencer;

  localparam int         BPB     = 20;
  localparam int         DEPTH   = 32;
  localparam int         DRAIN   = 4;
  localparam logic [7:0] IDLE_ID = 8'hFF;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tracing_req;
  logic       cfg_wr_valid;
  logic [7:0] cfg_wr_data;
  logic       cfg_wr_ready;
  logic       start;
  logic [7:0] block_id;
  logic       tracing;
  logic [7:0] configId;
  logic [7:0] configData;
  logic       busy;
  logic       done;
  logic       error;
  logic [5:0] fifo_count;
`ifdef CFG_CHECKSUM_EN
  logic [7:0] cfg_checksum;
`endif

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] model_q[$];

  alu_config_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tracing_req  (tracing_req),
    .cfg_wr_valid (cfg_wr_valid),
    .cfg_wr_data  (cfg_wr_data),
    .cfg_wr_ready (cfg_wr_ready),
    .start        (start),
    .block_id     (block_id),
    .tracing      (tracing),
    .configId     (configId),
    .configData   (configData),
    .busy         (busy),
    .done         (done),
    .error        (error),
`ifdef CFG_CHECKSUM_EN
    .cfg_checksum (cfg_checksum),
`endif
    .fifo_count   (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Starts and ends at a falling edge; records an accepted push into the model at the rising edge.
  task automatic tick();
    logic pushed;
    logic [7:0] pdat;
    pushed = cfg_wr_valid && cfg_wr_ready;
    pdat   = cfg_wr_data;
    @(posedge clk);
    if (pushed) model_q.push_back(pdat);
    @(negedge clk);
    if (cfg_wr_valid) cfg_wr_data = cfg_wr_data + 8'd1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    cfg_wr_valid = 1'b1;
    cfg_wr_data  = b;
    tick();
    cfg_wr_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_tracing"},  tracing,      0);
    chk({pfx, "_configId"}, configId,     IDLE_ID);
    chk({pfx, "_cfgData"},  configData,   0);
    chk({pfx, "_busy"},     busy,         0);
    chk({pfx, "_done"},     done,         0);
    chk({pfx, "_error"},    error,        0);
    chk({pfx, "_count"},    fifo_count,   0);
    chk({pfx, "_ready"},    cfg_wr_ready, 1);
  endtask

  task automatic do_load(input logic [7:0] id, input bit push_during,
                         input int restart_at, input int reset_at);
    logic [7:0] exp_b;
    logic [7:0] sum;
    sum          = 8'd0;
    cfg_wr_valid = push_during;
    start        = 1'b1;
    block_id     = id;
    tick();
    start = 1'b0;
    chk("start_tracing_low", tracing, 0);
    chk("start_busy", busy, 1);
    chk("start_no_error", error, 0);
    for (int i = 1; i < DRAIN; i++) begin
      tick();
      chk("drain_configId", configId, IDLE_ID);
      chk("drain_tracing", tracing, 0);
    end
    for (int b = 0; b < BPB; b++) begin
      if (b == restart_at) begin
        start    = 1'b1;
        block_id = 8'h33;
      end
      tick();
      start = 1'b0;
      exp_b = (model_q.size() > 0) ? model_q.pop_front() : 8'hxx;
      sum   = sum + exp_b;
      chk("load_configId", configId, id);
      chk("load_configData", configData, exp_b);
      chk("load_count", fifo_count, model_q.size());
      chk("load_count_le_depth", fifo_count <= DEPTH, 1);
      if (b == restart_at) chk("busy_start_no_error", error, 0);
      if (b == reset_at) begin
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midload_rst");
        model_q.delete();
        cfg_wr_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_configId", configId, IDLE_ID);
        chk("post_rst_count", fifo_count, 0);
        chk("post_rst_busy", busy, 0);
        tick();
        chk("post_rst_tracing", tracing, tracing_req);
        return;
      end
    end
    cfg_wr_valid = 1'b0;
    tick();
    chk("gap_configId", configId, IDLE_ID);
    chk("gap_done", done, 1);
    chk("gap_busy", busy, 1);
    chk("gap_tracing", tracing, 0);
`ifdef CFG_CHECKSUM_EN
    chk("checksum_at_done", cfg_checksum, sum);
`endif
    tick();
    chk("end_done_clear", done, 0);
    chk("end_busy_clear", busy, 0);
    chk("end_tracing_restored", tracing, tracing_req);
  endtask

  initial begin
    rst_n        = 1'b0;
    tracing_req  = 1'b0;
    cfg_wr_valid = 1'b0;
    cfg_wr_data  = 8'd0;
    start        = 1'b0;
    block_id     = 8'd0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n       = 1'b1;
    tracing_req = 1'b1;
    tick();
    tick();
    chk("idle_tracing_follows", tracing, 1);

    // Basic load of bytes 0..19 into block 0.
    for (int i = 0; i < BPB; i++) push_byte(8'(i));
    chk("fill20_count", fifo_count, 20);
    do_load(8'd0, 1'b0, -1, -1);
    chk("after_load0_count", fifo_count, 0);

    // Too few bytes: rejected, then accepted after one more push.
    for (int i = 0; i < BPB - 1; i++) push_byte(8'(8'h40 + i));
    start    = 1'b1;
    block_id = 8'd5;
    tick();
    start = 1'b0;
    chk("short_error_pulse", error, 1);
    chk("short_tracing_kept", tracing, 1);
    chk("short_count", fifo_count, 19);
    chk("short_not_busy", busy, 0);
    tick();
    chk("short_error_one_cycle", error, 0);
    push_byte(8'h53);
    do_load(8'd5, 1'b0, -1, -1);

    // Idle id as target is rejected with no state change.
    for (int i = 0; i < BPB; i++) push_byte(8'(8'hA0 + i));
    start    = 1'b1;
    block_id = IDLE_ID;
    tick();
    start = 1'b0;
    chk("idle_id_error", error, 1);
    chk("idle_id_not_busy", busy, 0);
    chk("idle_id_count", fifo_count, 20);
    chk("idle_id_configId", configId, IDLE_ID);

    // Fill to full, drop extra pushes, then keep pushing through a load.
    for (int i = 0; i < DEPTH - BPB; i++) push_byte(8'(8'hC0 + i));
    chk("full_count", fifo_count, DEPTH);
    chk("full_ready_low", cfg_wr_ready, 0);
    push_byte(8'hEE);
    push_byte(8'hEF);
    chk("full_drop_count", fifo_count, DEPTH);
    cfg_wr_data = 8'h10;
    do_load(8'd7, 1'b1, -1, -1);
    chk("overflow_load_count", fifo_count, model_q.size());

    // Start while busy is ignored; reset after LOAD byte 7.
    do_load(8'd9, 1'b0, 3, 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
